// File: rtl/spi_cmd_decoder.sv
// ---------------------------------------------------------------------------
// spi_cmd_decoder
//
// Interprets the stream of 32-bit words delivered by the SPI slave as host
// commands. It handles burst writes into the vertex/face memory, burst reads
// back out over SPI, a subdivision start kick and a status query. It is the
// only path from the external SPI master to chip state.
//
// Command word: opcode [31:28], count [27:16], addr [ADDR_WIDTH-1:0].
//   0x0 NOP, 0x1 WRITE, 0x2 READ, 0x3 START, 0x4 STATUS, 0x5-0xF illegal.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   rx_valid, rx_data one-cycle pulse with a complete received word
//   tx_data, tx_load  word for the next SPI frame; pulse on every update
//   mem_we, mem_re    registered one-cycle memory strobes
//   mem_addr          memory word address
//   mem_wdata         write data
//   mem_rdata         read data, valid the cycle after mem_re
//   core_start        one-cycle kick to the subdivision core
//   core_busy         subdivision core running
//   busy              FSM outside IDLE (registered)
//   err               sticky protocol error, cleared by STATUS
// ---------------------------------------------------------------------------
module spi_cmd_decoder #(
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [31:0]           rx_data,
  output logic [31:0]           tx_data,
  output logic                  tx_load,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  core_start,
  input  logic                  core_busy,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_RD_FETCH,
    ST_RD_DATA
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_WRITE  = 4'h1,
    OP_READ   = 4'h2,
    OP_START  = 4'h3,
    OP_STATUS = 4'h4
  } opcode_t;

  // Command fields of the incoming word
  opcode_t               cmd_op;
  logic [11:0]           cmd_count;
  logic [ADDR_WIDTH-1:0] cmd_addr;

  assign cmd_op    = opcode_t'(rx_data[31:28]);
  assign cmd_count = rx_data[27:16];
  assign cmd_addr  = rx_data[ADDR_WIDTH-1:0];

  // Bits between the address field and the count field carry no meaning.
  if (ADDR_WIDTH < 16) begin : g_unused_addr_bits
    logic unused_addr_bits;
    assign unused_addr_bits = ^rx_data[15:ADDR_WIDTH];
  end

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [11:0]           count_q, count_d;
  logic [31:0]           tx_data_q, tx_data_d;
  logic                  tx_load_q, tx_load_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_re_q, mem_re_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  core_start_q, core_start_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path through
    // this block leaves one unassigned; that is what keeps it free of latches.
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    tx_data_d    = tx_data_q;
    tx_load_d    = 1'b0;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_start_d = 1'b0;
    err_d        = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          case (cmd_op)
            OP_NOP: ;
            OP_WRITE: begin
              if (cmd_count != 12'd0) begin
                addr_d  = cmd_addr;
                count_d = cmd_count;
                state_d = ST_WR_DATA;
              end
            end
            OP_READ: begin
              if (cmd_count != 12'd0) begin
                addr_d     = cmd_addr;
                count_d    = cmd_count;
                mem_addr_d = cmd_addr;
                mem_re_d   = 1'b1;
                state_d    = ST_RD_FETCH;
              end
            end
            OP_START: begin
              if (core_busy) err_d        = 1'b1;
              else           core_start_d = 1'b1;
            end
            OP_STATUS: begin
              // Report the current flag, then clear it in the same update.
              tx_data_d = {16'hC0DE, 14'b0, err_q, core_busy};
              tx_load_d = 1'b1;
              err_d     = 1'b0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ST_WR_DATA: begin
        if (rx_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = rx_data;
          addr_d      = addr_q + 1'b1;
          count_d     = count_q - 1'b1;
          if (count_q == 12'd1) state_d = ST_IDLE;
        end
      end

      ST_RD_FETCH: begin
        // A word arriving while a fetch is outstanding has nowhere to go.
        if (rx_valid) err_d = 1'b1;
        // First cycle here has mem_re on the port; read data lands the next.
        if (!mem_re_q) begin
          tx_data_d = mem_rdata;
          tx_load_d = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        // The received word is the dummy the host clocked in while reading.
        if (rx_valid) begin
          count_d = count_q - 1'b1;
          if (count_q == 12'd1) begin
            tx_data_d = 32'h0;
            tx_load_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            addr_d     = addr_q + 1'b1;
            mem_addr_d = addr_q + 1'b1;
            mem_re_d   = 1'b1;
            state_d    = ST_RD_FETCH;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      count_q      <= '0;
      tx_data_q    <= '0;
      tx_load_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values decoded from the previous state, independent of statement order.
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      tx_data_q    <= tx_data_d;
      tx_load_q    <= tx_load_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_load    = tx_load_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_start = core_start_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_spi_cmd_decoder
//
// Directed bench for spi_cmd_decoder. A table of single-word commands with
// hand-computed expected outputs one cycle later, followed by hand-written
// read bursts, a read with a word injected during the fetch, and a reset in
// the middle of a write burst. A small behavioural memory with one-cycle read
// latency answers mem_re.
// ---------------------------------------------------------------------------
module tb_spi_cmd_decoder;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [31:0]   rx_data = 32'h0;
  logic [31:0]   tx_data;
  logic          tx_load;
  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic          core_start;
  logic          core_busy = 1'b0;
  logic          busy;
  logic          err;

  spi_cmd_decoder #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .core_start (core_start),
    .core_busy  (core_busy),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Behavioural memory, one-cycle synchronous read
  logic [31:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    mem[11'h010] = 32'h11111111;
    mem[11'h011] = 32'h22222222;
    mem[11'h7FF] = 32'h5A5A7FFF;
    mem[11'h000] = 32'hA5A50000;
  end
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Pulse counters sampled away from the active edge
  int tx_load_cnt = 0;
  int mem_we_cnt  = 0;
  always @(negedge clk) begin
    if (tx_load) tx_load_cnt++;
    if (mem_we)  mem_we_cnt++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // {mem_we, mem_re, tx_load, core_start, err, busy}
  function automatic logic [5:0] flags();
    return {mem_we, mem_re, tx_load, core_start, err, busy};
  endfunction

  // Drives one rx_valid pulse; returns at the negedge of the following cycle.
  task automatic send(input logic [31:0] w, input logic cb);
    @(negedge clk);
    rx_valid  = 1'b1;
    rx_data   = w;
    core_busy = cb;
    @(negedge clk);
    rx_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx_load(input string name, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_load) begin
        found = 1'b1;
        break;
      end
    end
    check(name, {31'h0, found}, 32'h1);
  endtask

  typedef struct {
    logic [31:0]   word;
    logic          cbusy;
    logic [5:0]    flg;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   txd;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    int base;

    //              word          cb    we re tl cs er by  addr     wdata         tx_data
    vecs[0]  = '{32'h00000000, 1'b0, 6'b000000, 11'h000, 32'h00000000, 32'h00000000}; // NOP
    vecs[1]  = '{32'h10000005, 1'b0, 6'b000000, 11'h000, 32'h00000000, 32'h00000000}; // WRITE count 0
    vecs[2]  = '{32'h100307FE, 1'b0, 6'b000001, 11'h000, 32'h00000000, 32'h00000000}; // WRITE 0x7FE x3
    vecs[3]  = '{32'hAAAA0001, 1'b0, 6'b100001, 11'h7FE, 32'hAAAA0001, 32'h00000000};
    vecs[4]  = '{32'hAAAA0002, 1'b0, 6'b100001, 11'h7FF, 32'hAAAA0002, 32'h00000000};
    vecs[5]  = '{32'hAAAA0003, 1'b0, 6'b100000, 11'h000, 32'hAAAA0003, 32'h00000000}; // wrap, busy falls
    vecs[6]  = '{32'h30000000, 1'b0, 6'b000100, 11'h000, 32'hAAAA0003, 32'h00000000}; // START ok
    vecs[7]  = '{32'h30000000, 1'b1, 6'b000010, 11'h000, 32'hAAAA0003, 32'h00000000}; // START while busy
    vecs[8]  = '{32'h40000000, 1'b0, 6'b001000, 11'h000, 32'hAAAA0003, 32'hC0DE0002}; // STATUS clears err
    vecs[9]  = '{32'h90000000, 1'b0, 6'b000010, 11'h000, 32'hAAAA0003, 32'hC0DE0002}; // opcode 0x9
    vecs[10] = '{32'h40000000, 1'b0, 6'b001000, 11'h000, 32'hAAAA0003, 32'hC0DE0002};
    vecs[11] = '{32'h40000000, 1'b0, 6'b001000, 11'h000, 32'hAAAA0003, 32'hC0DE0000};
    vecs[12] = '{32'h40000000, 1'b1, 6'b001000, 11'h000, 32'hAAAA0003, 32'hC0DE0001};
    vecs[13] = '{32'hF0000000, 1'b0, 6'b000010, 11'h000, 32'hAAAA0003, 32'hC0DE0001}; // opcode 0xF
    vecs[14] = '{32'h20000010, 1'b0, 6'b000010, 11'h000, 32'hAAAA0003, 32'hC0DE0001}; // READ count 0
    vecs[15] = '{32'h40000000, 1'b0, 6'b001000, 11'h000, 32'hAAAA0003, 32'hC0DE0002};

    // ---- reset state ----
    idle(3);
    check("reset flags",     {26'h0, flags()},  32'h0);
    check("reset tx_data",   tx_data,           32'h0);
    check("reset mem_addr",  {21'h0, mem_addr}, 32'h0);
    check("reset mem_wdata", mem_wdata,         32'h0);
    reset = 1'b0;
    idle(2);

    // ---- single-word command table ----
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].word, vecs[i].cbusy);
      check($sformatf("vec%0d flags", i),     {26'h0, flags()},  {26'h0, vecs[i].flg});
      check($sformatf("vec%0d mem_addr", i),  {21'h0, mem_addr}, {21'h0, vecs[i].addr});
      check($sformatf("vec%0d mem_wdata", i), mem_wdata,         vecs[i].wdata);
      check($sformatf("vec%0d tx_data", i),   tx_data,           vecs[i].txd);
      @(negedge clk);
      check($sformatf("vec%0d pulses drop", i), {28'h0, mem_we, mem_re, tx_load, core_start}, 32'h0);
      idle(1);
    end
    check("written 0x7FE", mem[11'h7FE], 32'hAAAA0001);
    check("written 0x7FF", mem[11'h7FF], 32'hAAAA0002);
    check("written 0x000", mem[11'h000], 32'hAAAA0003);

    // ---- READ 0x010 x2 ----
    base = tx_load_cnt;
    send(32'h20020010, 1'b0);
    check("rdA cmd flags", {26'h0, flags()},  {26'h0, 6'b010001});
    check("rdA cmd addr",  {21'h0, mem_addr}, 32'h010);
    wait_tx_load("rdA load1", 8);
    check("rdA data1",  tx_data, 32'h11111111);
    check("rdA flags1", {26'h0, flags()}, {26'h0, 6'b001001});
    idle(2);
    send(32'h0, 1'b0);
    check("rdA dummy1 flags", {26'h0, flags()},  {26'h0, 6'b010001});
    check("rdA dummy1 addr",  {21'h0, mem_addr}, 32'h011);
    wait_tx_load("rdA load2", 8);
    check("rdA data2", tx_data, 32'h22222222);
    idle(2);
    send(32'h0, 1'b0);
    check("rdA end flags", {26'h0, flags()}, {26'h0, 6'b001000});
    check("rdA end data",  tx_data, 32'h0);
    idle(2);
    check("rdA tx_load count", tx_load_cnt - base, 3);

    // ---- READ 0x7FF x2 with a word injected during the fetch ----
    send(32'h200207FF, 1'b0);
    check("rdB cmd flags", {26'h0, flags()},  {26'h0, 6'b010001});
    check("rdB cmd addr",  {21'h0, mem_addr}, 32'h7FF);
    send(32'hDEADBEEF, 1'b0);
    check("rdB inject flags", {26'h0, flags()}, {26'h0, 6'b001011});
    check("rdB data1", tx_data, 32'hAAAA0002);
    idle(2);
    send(32'h0, 1'b0);
    check("rdB dummy1 flags", {26'h0, flags()},  {26'h0, 6'b010011});
    check("rdB wrap addr",    {21'h0, mem_addr}, 32'h000);
    wait_tx_load("rdB load2", 8);
    check("rdB data2", tx_data, 32'hAAAA0003);
    idle(2);
    send(32'h0, 1'b0);
    check("rdB end flags", {26'h0, flags()}, {26'h0, 6'b001010});
    check("rdB end data",  tx_data, 32'h0);
    idle(2);
    send(32'h40000000, 1'b0);
    check("rdB status", tx_data, 32'hC0DE0002);
    check("rdB status flags", {26'h0, flags()}, {26'h0, 6'b001000});
    idle(2);

    // ---- reset in the middle of WRITE 0x100 x4 ----
    send(32'h10040100, 1'b0);
    check("rst wr cmd flags", {26'h0, flags()}, {26'h0, 6'b000001});
    idle(2);
    send(32'h05550001, 1'b0);
    check("rst wr d1 flags", {26'h0, flags()},  {26'h0, 6'b100001});
    check("rst wr d1 addr",  {21'h0, mem_addr}, 32'h100);
    idle(2);
    send(32'h05550002, 1'b0);
    check("rst wr d2 flags", {26'h0, flags()},  {26'h0, 6'b100001});
    check("rst wr d2 addr",  {21'h0, mem_addr}, 32'h101);
    #2 reset = 1'b1;
    #1;
    check("rst async flags",     {26'h0, flags()},  32'h0);
    check("rst async mem_addr",  {21'h0, mem_addr}, 32'h0);
    check("rst async mem_wdata", mem_wdata,         32'h0);
    check("rst async tx_data",   tx_data,           32'h0);
    idle(2);
    reset = 1'b0;
    base = mem_we_cnt;
    idle(1);
    send(32'h01234567, 1'b0);
    check("rst after w3 flags", {26'h0, flags()}, 32'h0);
    idle(2);
    send(32'h0BAD0002, 1'b0);
    check("rst after w4 flags", {26'h0, flags()}, 32'h0);
    idle(2);
    check("rst no mem_we", mem_we_cnt - base, 0);
    check("rst mem 0x102 untouched", mem[11'h102], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Command decoder that sits directly downstream of the SPI slave inside `top`. It consumes each received 32-bit word and interprets the stream as host commands: burst writes into the on-chip vertex/face memory, burst reads back out over SPI, a subdivision start kick, and a status query. It drives the memory port and the SPI slave's transmit word. It is the only path between the external SPI master and chip state.

## Interface
- `ADDR_WIDTH`, 11, memory word-address width; must be ≤ 16.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: one-cycle pulse from the SPI slave; `rx_data` holds a complete received word.
- `rx_data` in 32: received word.
- `tx_data` out 32: word the SPI slave shifts out on the next frame.
- `tx_load` out 1: one-cycle pulse whenever `tx_data` changes.
- `mem_we` out 1: memory write strobe.
- `mem_re` out 1: memory read strobe; `mem_rdata` is valid the following cycle.
- `mem_addr` out ADDR_WIDTH: memory address.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, 1-cycle synchronous latency.
- `core_start` out 1: one-cycle pulse that starts the subdivision core.
- `core_busy` in 1: subdivision core running.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `err` out 1: sticky protocol-error flag.

## Operation
- Command word fields:
  - opcode `[31:28]`: 0x0 NOP, 0x1 WRITE, 0x2 READ, 0x3 START, 0x4 STATUS.
  - count `[27:16]`: 12-bit unsigned word count.
  - addr `[ADDR_WIDTH-1:0]`: start address; all other bits are ignored.
- States: IDLE, WR_DATA, RD_FETCH, RD_DATA.
- IDLE, on `rx_valid`:
  - WRITE with count>0: latch addr and count, go to WR_DATA.
  - READ with count>0: latch addr and count, assert `mem_re` next cycle, go to RD_FETCH.
  - WRITE or READ with count=0: no operation, stay in IDLE.
  - START: if `core_busy`=0, pulse `core_start` next cycle; else set `err`, no pulse.
  - STATUS: `tx_data` <= {16'hC0DE, 14'b0, err, core_busy}, pulse `tx_load`, then clear `err` in the same cycle.
  - NOP: nothing happens.
  - Opcodes 0x5–0xF: set `err`, otherwise ignored.
- WR_DATA, on `rx_valid`:
  - Next cycle: `mem_we`=1, `mem_addr`=current address, `mem_wdata`=`rx_data`.
  - Address increments mod 2^ADDR_WIDTH; count decrements.
  - When count reaches 0, return to IDLE.
- RD_FETCH: the cycle after `mem_re`, register `mem_rdata` into `tx_data`, pulse `tx_load`, go to RD_DATA.
  - `rx_valid` arriving in RD_FETCH: word dropped, `err` set, state unchanged.
- RD_DATA, on `rx_valid`: the received word is a dummy (the host clocked out `tx_data` during that frame); decrement count.
  - Count now 0: `tx_data` <= 0, pulse `tx_load`, go to IDLE.
  - Otherwise: address+1 (wraps), `mem_re` next cycle, go to RD_FETCH.
- Address wraps 2^ADDR_WIDTH−1 → 0 for both reads and writes; counts above 2^ADDR_WIDTH simply wrap.
- No command aborts an in-progress burst; all words received in WR_DATA/RD_DATA are treated as data.

## Timing
- Reset (asynchronous): state IDLE; `tx_data`=0; `mem_addr`=0; `mem_wdata`=0; `busy`=0; `err`=0; `tx_load`, `mem_we`, `mem_re`, `core_start` all 0.
- Reset asserted mid-burst abandons the burst immediately; no further memory strobes are issued.
- `mem_we`, `mem_re`, `core_start`, `tx_load` are registered one-cycle pulses, never asserted in two consecutive cycles by the same event.
- Latencies, measured from the `rx_valid` cycle N:
  - Write data word: `mem_we` at N+1.
  - READ command or RD_DATA dummy word: `mem_re` at N+1; `tx_data`/`tx_load` at N+2.
  - STATUS: `tx_data`/`tx_load` at N+1.
  - START: `core_start` at N+1.
- `busy` is registered and goes high at N+1 after a burst command is accepted.
- Upstream contract: `rx_valid` pulses are ≥ 3 cycles apart; any SPI frame at the slowest clock divider satisfies this.

## Test plan
- Reset mid-WRITE burst (count=4, after 2 data words) → no further `mem_we`; `busy`=0; all outputs at reset values.
- WRITE addr=0x7FE, count=3, data 0xAAAA0001/2/3 → `mem_we` pulses at addresses 0x7FE, 0x7FF, 0x000 with matching data; `busy` falls after the third word.
- READ addr=0x010, count=2 with memory preloaded 0x11111111, 0x22222222 → `tx_data` = 0x11111111, then 0x22222222 after the first dummy, then 0 after the second; three `tx_load` pulses.
- START with `core_busy`=0 → one `core_start` pulse; START with `core_busy`=1 → no pulse, `err`=1.
- Opcode 0x9 sets `err`; a following STATUS gives `tx_data`=0xC0DE0002 (err=1, core_busy=0) and `err` clears; a second STATUS gives 0xC0DE0000.
- WRITE count=0 and NOP → no memory strobes, `busy` stays 0; `rx_valid` injected during RD_FETCH → `err`=1 and the read sequence still completes.
